// File: rtl/whack_pkg.sv
// rtl/whack_pkg.sv - shared types, widths and default timing for the whack-a-mole controller
package whack_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GAP  = 2'd1,
        ST_UP   = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam int RAND_W  = 5;
    localparam int HOLE_W  = 4;
    localparam int SCORE_W = 8;
    localparam int TIMER_W = 8;

    localparam int DEF_NUM_HOLES = 16;
    localparam int DEF_UP_TICKS  = 8;
    localparam int DEF_GAP_TICKS = 4;
    localparam int DEF_ROUNDS    = 20;

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
        return (v == {SCORE_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/tick_timer.sv
// rtl/tick_timer.sv - loadable down-counter advanced by a tick enable
module tick_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         tick,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero,
    output logic         expire
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Load has priority so a round can restart the timer on its final tick.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en && tick && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero   = (count_q == '0);
    assign expire = en && tick && (count_q == W'(1));

endmodule

// File: rtl/mole_ctrl.sv
// rtl/mole_ctrl.sv - round sequencer: samples the random source, shows a mole, judges hits
module mole_ctrl
    import whack_pkg::*;
#(
    parameter int NUM_HOLES = DEF_NUM_HOLES,
    parameter int UP_TICKS  = DEF_UP_TICKS,
    parameter int GAP_TICKS = DEF_GAP_TICKS,
    parameter int ROUNDS    = DEF_ROUNDS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tick,
    input  logic                 start,
    input  logic [RAND_W-1:0]    rand_in,
    input  logic                 hit_valid,
    input  logic [HOLE_W-1:0]    hit_idx,
    output logic [NUM_HOLES-1:0] mole_onehot,
    output logic [HOLE_W-1:0]    mole_idx,
    output logic                 mole_active,
    output logic [SCORE_W-1:0]   score,
    output logic [SCORE_W-1:0]   misses,
    output logic                 hit_pulse,
    output logic                 miss_pulse,
    output logic                 game_over
);

    localparam logic [HOLE_W-1:0] HOLE_MASK = HOLE_W'(NUM_HOLES - 1);

    state_e               state_q, state_d;
    logic [7:0]           rounds_q, rounds_d;
    logic [NUM_HOLES-1:0] mole_onehot_q, mole_onehot_d;
    logic [HOLE_W-1:0]    mole_idx_q, mole_idx_d;
    logic                 mole_active_q, mole_active_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic [SCORE_W-1:0]   misses_q, misses_d;
    logic                 hit_pulse_q, hit_pulse_d;
    logic                 miss_pulse_q, miss_pulse_d;
    logic                 game_over_q, game_over_d;

    logic gap_load, gap_en, gap_zero, gap_expire;
    logic up_load, up_en, up_zero, up_expire;
    logic correct_hit, end_round;
    logic [HOLE_W-1:0] raw_idx, pick_idx;
    logic unused_ok;

    tick_timer #(.W(TIMER_W)) u_gap_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (gap_en),
        .tick     (tick),
        .load     (gap_load),
        .load_val (TIMER_W'(GAP_TICKS)),
        .zero     (gap_zero),
        .expire   (gap_expire)
    );

    tick_timer #(.W(TIMER_W)) u_up_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (up_en),
        .tick     (tick),
        .load     (up_load),
        .load_val (TIMER_W'(UP_TICKS)),
        .zero     (up_zero),
        .expire   (up_expire)
    );

    assign unused_ok = &{1'b0, gap_expire, up_zero};

    // The same hole twice in a row is bumped to its neighbour.
    assign raw_idx  = rand_in[HOLE_W-1:0] & HOLE_MASK;
    assign pick_idx = ((raw_idx == mole_idx_q) && (rounds_q != 8'd0))
                      ? ((raw_idx + 1'b1) & HOLE_MASK) : raw_idx;

    assign correct_hit = hit_valid && (hit_idx == mole_idx_q);

    always_comb begin
        state_d       = state_q;
        rounds_d      = rounds_q;
        mole_idx_d    = mole_idx_q;
        mole_active_d = mole_active_q;
        score_d       = score_q;
        misses_d      = misses_q;
        game_over_d   = game_over_q;
        hit_pulse_d   = 1'b0;
        miss_pulse_d  = 1'b0;
        gap_load      = 1'b0;
        up_load       = 1'b0;
        end_round     = 1'b0;
        gap_en        = (state_q == ST_GAP);
        up_en         = (state_q == ST_UP);

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d     = ST_GAP;
                    gap_load    = 1'b1;
                    rounds_d    = 8'd0;
                    score_d     = '0;
                    misses_d    = '0;
                    game_over_d = 1'b0;
                end
            end
            ST_GAP: begin
                if (gap_zero && (rand_in != '0)) begin
                    mole_idx_d    = pick_idx;
                    mole_active_d = 1'b1;
                    up_load       = 1'b1;
                    state_d       = ST_UP;
                end
            end
            ST_UP: begin
                // A hit on the expiry tick is scored; the miss is dropped.
                if (correct_hit) begin
                    hit_pulse_d = 1'b1;
                    score_d     = sat_inc(score_q);
                    end_round   = 1'b1;
                end else if (up_expire) begin
                    miss_pulse_d = 1'b1;
                    misses_d     = sat_inc(misses_q);
                    end_round    = 1'b1;
                end
                if (end_round) begin
                    mole_active_d = 1'b0;
                    rounds_d      = rounds_q + 8'd1;
                    if (rounds_d == 8'(ROUNDS)) begin
                        state_d     = ST_DONE;
                        game_over_d = 1'b1;
                    end else begin
                        state_d  = ST_GAP;
                        gap_load = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        mole_onehot_d = mole_active_d ? (NUM_HOLES'(1) << mole_idx_d) : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            rounds_q      <= 8'd0;
            mole_onehot_q <= '0;
            mole_idx_q    <= '0;
            mole_active_q <= 1'b0;
            score_q       <= '0;
            misses_q      <= '0;
            hit_pulse_q   <= 1'b0;
            miss_pulse_q  <= 1'b0;
            game_over_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            rounds_q      <= rounds_d;
            mole_onehot_q <= mole_onehot_d;
            mole_idx_q    <= mole_idx_d;
            mole_active_q <= mole_active_d;
            score_q       <= score_d;
            misses_q      <= misses_d;
            hit_pulse_q   <= hit_pulse_d;
            miss_pulse_q  <= miss_pulse_d;
            game_over_q   <= game_over_d;
        end
    end

    assign mole_onehot = mole_onehot_q;
    assign mole_idx    = mole_idx_q;
    assign mole_active = mole_active_q;
    assign score       = score_q;
    assign misses      = misses_q;
    assign hit_pulse   = hit_pulse_q;
    assign miss_pulse  = miss_pulse_q;
    assign game_over   = game_over_q;

endmodule
